// File: rtl/memory_io_responder.sv
// memory_io_responder
// Responder end of the core's data-memory port. Holds the data RAM at the
// bottom of the address space and a small memory-mapped I/O block at IO_BASE:
//   IO_BASE+0 TXDATA  write pushes a word into the TX FIFO, read returns 0
//   IO_BASE+1 STATUS  {tx_count[7:4], tx_overflow, rx_held, tx_empty, tx_full}
//   IO_BASE+2 RXDATA  read returns the held host word (0 if none), write releases it
//   IO_BASE+3 CYCLES  free-running cycle counter when enabled
// Build option: define MEMORY_IO_CYCLE_COUNTER_EN to include the CYCLES counter;
// without it CYCLES reads 0 and writes to it are ignored.
// Loads are combinational and side-effect free; the core has no read strobe,
// so consuming an RX word is an explicit store to RXDATA.

module memory_io_responder #(
    parameter int                    ADDR_SIZE  = 18,
    parameter int                    WORD_SIZE  = 18,
    parameter int                    MEM_SIZE   = 1024,
    parameter int                    FIFO_DEPTH = 8,
    parameter logic [ADDR_SIZE-1:0]  IO_BASE    = 18'h3FF00
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 memory_write_enable,
    input  logic [ADDR_SIZE-1:0] memory_addr,
    input  logic [WORD_SIZE-1:0] memory_in,
    output logic [WORD_SIZE-1:0] memory_out,
    output logic [WORD_SIZE-1:0] tx_data,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    input  logic [WORD_SIZE-1:0] rx_data,
    input  logic                 rx_valid,
    output logic                 rx_ready
);

    // ------------------------------------------------------------------
    // Derived sizes and register addresses
    // ------------------------------------------------------------------
    localparam int IDX_W = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [ADDR_SIZE-1:0] MEM_LIMIT    = ADDR_SIZE'(MEM_SIZE);
    localparam logic [ADDR_SIZE-1:0] ADDR_TXDATA  = IO_BASE;
    localparam logic [ADDR_SIZE-1:0] ADDR_STATUS  = IO_BASE + ADDR_SIZE'(1);
    localparam logic [ADDR_SIZE-1:0] ADDR_RXDATA  = IO_BASE + ADDR_SIZE'(2);
    localparam logic [ADDR_SIZE-1:0] ADDR_CYCLES  = IO_BASE + ADDR_SIZE'(3);

    localparam logic [CNT_W-1:0]     FULL_COUNT   = CNT_W'(FIFO_DEPTH);

    // STATUS bit positions
    localparam int ST_TX_FULL  = 0;
    localparam int ST_TX_EMPTY = 1;
    localparam int ST_RX_HELD  = 2;
    localparam int ST_TX_OVF   = 3;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic             sel_ram;
    logic             sel_txdata;
    logic             sel_status;
    logic             sel_rxdata;
    logic             sel_cycles;
    logic [IDX_W-1:0] ram_idx;

    assign sel_ram    = (memory_addr < MEM_LIMIT);
    assign sel_txdata = (memory_addr == ADDR_TXDATA);
    assign sel_status = (memory_addr == ADDR_STATUS);
    assign sel_rxdata = (memory_addr == ADDR_RXDATA);
    assign sel_cycles = (memory_addr == ADDR_CYCLES);
    assign ram_idx    = memory_addr[IDX_W-1:0];

    logic wr_ram;
    logic wr_txdata;
    logic wr_status;
    logic wr_rxdata;

    assign wr_ram    = memory_write_enable & sel_ram;
    assign wr_txdata = memory_write_enable & sel_txdata;
    assign wr_status = memory_write_enable & sel_status;
    assign wr_rxdata = memory_write_enable & sel_rxdata;

    // ------------------------------------------------------------------
    // Data RAM
    // ------------------------------------------------------------------
    logic [WORD_SIZE-1:0] mem_q [MEM_SIZE];

    // RAM write port; a load in the following cycle sees the new word.
    // NOTE: storage arrays get no reset branch, so they map onto RAM/LUTRAM
    // instead of thousands of resettable flops.
    always_ff @(posedge clock) begin
        if (wr_ram) begin
            mem_q[ram_idx] <= memory_in;
        end
    end

    // ------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------
    logic [WORD_SIZE-1:0] fifo_q [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q,  count_d;
    logic                 overflow_q, overflow_d;

    logic tx_full;
    logic tx_empty;
    logic tx_pop;
    logic push_accept;
    logic push_drop;

    assign tx_full     = (count_q == FULL_COUNT);
    assign tx_empty    = (count_q == '0);
    assign tx_valid    = ~tx_empty;
    assign tx_data     = fifo_q[rd_ptr_q];
    assign tx_pop      = tx_valid & tx_ready;
    // A push into a full FIFO still fits when the head leaves on the same edge.
    assign push_accept = wr_txdata & (~tx_full | tx_pop);
    assign push_drop   = wr_txdata & tx_full & ~tx_pop;

    // FIFO storage write port.
    always_ff @(posedge clock) begin
        if (push_accept) begin
            fifo_q[wr_ptr_q] <= memory_in;
        end
    end

    // FIFO pointers, occupancy and the sticky overflow flag.
    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        if (push_accept) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (tx_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        case ({push_accept, tx_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // A fresh drop on the same edge as a clear wins, so no lost word
        // goes unreported.
        if (wr_status && memory_in[ST_TX_OVF]) begin
            overflow_d = 1'b0;
        end
        if (push_drop) begin
            overflow_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // RX holding register
    // ------------------------------------------------------------------
    logic                 rx_held_q, rx_held_d;
    logic [WORD_SIZE-1:0] rx_word_q, rx_word_d;
    logic                 rx_capture;

    assign rx_ready   = ~rx_held_q;
    assign rx_capture = rx_valid & ~rx_held_q;

    // Capture a host word when empty; a release store empties the register.
    // A word taken on the same edge as a release is kept, since the host has
    // already seen it accepted.
    always_comb begin
        rx_held_d = rx_held_q;
        rx_word_d = rx_word_q;
        if (rx_capture) begin
            rx_held_d = 1'b1;
            rx_word_d = rx_data;
        end else if (wr_rxdata) begin
            rx_held_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Control state registers
    // ------------------------------------------------------------------

    // Synchronous reset empties the FIFO and RX register; RAM is untouched.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of its inputs, independent of block order.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            rx_held_q  <= 1'b0;
            rx_word_q  <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            rx_held_q  <= rx_held_d;
            rx_word_q  <= rx_word_d;
        end
    end

    // ------------------------------------------------------------------
    // Optional cycle counter
    // ------------------------------------------------------------------
    logic [WORD_SIZE-1:0] cycles_rd;

`ifdef MEMORY_IO_CYCLE_COUNTER_EN
    logic [WORD_SIZE-1:0] cycles_q, cycles_d;
    logic                 wr_cycles;

    assign wr_cycles = memory_write_enable & sel_cycles;
    assign cycles_rd = cycles_q;

    // Free-running count; a store preloads it and counting resumes from there.
    always_comb begin
        cycles_d = cycles_q + WORD_SIZE'(1);
        if (wr_cycles) begin
            cycles_d = memory_in;
        end
    end

    // Cycle counter register.
    always_ff @(posedge clock) begin
        if (reset) begin
            cycles_q <= '0;
        end else begin
            cycles_q <= cycles_d;
        end
    end
`else
    assign cycles_rd = '0;
`endif

    // ------------------------------------------------------------------
    // Load path
    // ------------------------------------------------------------------
    logic [WORD_SIZE-1:0] status_word;

    // Assemble the STATUS word; occupancy is fitted into a 4-bit field.
    always_comb begin
        status_word              = '0;
        status_word[ST_TX_FULL]  = tx_full;
        status_word[ST_TX_EMPTY] = tx_empty;
        status_word[ST_RX_HELD]  = rx_held_q;
        status_word[ST_TX_OVF]   = overflow_q;
        status_word[7:4]         = 4'(count_q);
    end

    // Zero-latency read mux; TXDATA and unmapped addresses read 0.
    always_comb begin
        memory_out = '0;
        if (sel_ram) begin
            memory_out = mem_q[ram_idx];
        end else if (sel_status) begin
            memory_out = status_word;
        end else if (sel_rxdata) begin
            memory_out = rx_held_q ? rx_word_q : '0;
        end else if (sel_cycles) begin
            memory_out = cycles_rd;
        end
    end

endmodule

// File: tb/tb_memory_io_responder.sv
// Self-checking bench for memory_io_responder: directed scenarios followed by
// a randomized run compared against a queue-based reference model.
// Build option: define MEMORY_IO_CYCLE_COUNTER_EN for both bench and design.

module tb_memory_io_responder;

    localparam int          MEM_SIZE = 1024;
    localparam int          DEPTH    = 8;
    localparam logic [17:0] IO_BASE  = 18'h3FF00;
    localparam logic [17:0] A_TX     = IO_BASE;
    localparam logic [17:0] A_STATUS = IO_BASE + 18'd1;
    localparam logic [17:0] A_RX     = IO_BASE + 18'd2;
    localparam logic [17:0] A_CYC    = IO_BASE + 18'd3;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        memory_write_enable = 1'b0;
    logic [17:0] memory_addr = '0;
    logic [17:0] memory_in = '0;
    logic [17:0] memory_out;
    logic [17:0] tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [17:0] rx_data = '0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;

    int total = 0;
    int bad   = 0;

    memory_io_responder dut (
        .clock               (clock),
        .reset               (reset),
        .memory_write_enable (memory_write_enable),
        .memory_addr         (memory_addr),
        .memory_in           (memory_in),
        .memory_out          (memory_out),
        .tx_data             (tx_data),
        .tx_valid            (tx_valid),
        .tx_ready            (tx_ready),
        .rx_data             (rx_data),
        .rx_valid            (rx_valid),
        .rx_ready            (rx_ready)
    );

    always #5 clock = ~clock;

    // ---------------- reference model ----------------
    logic [17:0] m_ram [MEM_SIZE];
    logic [17:0] m_fifo [$];
    logic        m_ovf  = 1'b0;
    logic        m_held = 1'b0;
    logic [17:0] m_rx   = '0;
    logic [17:0] m_cyc  = '0;

    // Apply the effect of the currently driven inputs at the coming edge.
    task automatic model_edge();
        logic pop, push, full;
        if (reset) begin
            m_fifo.delete();
            m_ovf  = 1'b0;
            m_held = 1'b0;
            m_cyc  = '0;
            return;
        end
        pop  = (m_fifo.size() > 0) && tx_ready;
        push = memory_write_enable && (memory_addr == A_TX);
        full = (m_fifo.size() == DEPTH);
        if (pop) void'(m_fifo.pop_front());
        if (memory_write_enable && memory_addr == A_STATUS && memory_in[3]) m_ovf = 1'b0;
        if (push) begin
            if (!full || pop) m_fifo.push_back(memory_in);
            else m_ovf = 1'b1;
        end
        if (!m_held && rx_valid) begin
            m_held = 1'b1;
            m_rx   = rx_data;
        end else if (memory_write_enable && memory_addr == A_RX) begin
            m_held = 1'b0;
        end
`ifdef MEMORY_IO_CYCLE_COUNTER_EN
        if (memory_write_enable && memory_addr == A_CYC) m_cyc = memory_in;
        else m_cyc = m_cyc + 18'd1;
`endif
        if (memory_write_enable && memory_addr < 18'(MEM_SIZE)) m_ram[memory_addr[9:0]] = memory_in;
    endtask

    function automatic logic [17:0] model_read(input logic [17:0] a);
        logic [17:0] s;
        if (a < 18'(MEM_SIZE)) return m_ram[a[9:0]];
        if (a == A_STATUS) begin
            s = '0;
            s[0] = (m_fifo.size() == DEPTH);
            s[1] = (m_fifo.size() == 0);
            s[2] = m_held;
            s[3] = m_ovf;
            s[7:4] = 4'(m_fifo.size());
            return s;
        end
        if (a == A_RX) return m_held ? m_rx : 18'd0;
`ifdef MEMORY_IO_CYCLE_COUNTER_EN
        if (a == A_CYC) return m_cyc;
`endif
        return 18'd0;
    endfunction

    // One clock edge: update the model, then settle just past the edge.
    task automatic cycle();
        model_edge();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic we, input logic [17:0] a, input logic [17:0] d);
        memory_write_enable = we;
        memory_addr = a;
        memory_in = d;
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1;
        cycle();
        cycle();
        reset = 1'b0;
        drive(0, A_CYC, 0);
        total++; if (memory_out !== 18'd0) begin bad++; $display("FAIL reset_cycles got=%h want=%h", memory_out, 18'd0); end
        drive(0, A_STATUS, 0);
        total++; if (memory_out !== 18'h2) begin bad++; $display("FAIL reset_status got=%h want=%h", memory_out, 18'h2); end
        total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL reset_tx_valid got=%b want=0", tx_valid); end
        total++; if (rx_ready !== 1'b1) begin bad++; $display("FAIL reset_rx_ready got=%b want=1", rx_ready); end
        cycle();
        drive(0, A_RX, 0);
        total++; if (memory_out !== 18'd0) begin bad++; $display("FAIL reset_rxdata got=%h want=%h", memory_out, 18'd0); end
        cycle();
    endtask

    task automatic test_ram();
        logic [17:0] vals [16];
        for (int i = 0; i < 16; i++) begin
            vals[i] = 18'($urandom);
            drive(1, 18'(i), vals[i]);
            cycle();
        end
        drive(1, 18'd5, 18'h2AAAA);
        cycle();
        vals[5] = 18'h2AAAA;
        drive(1, 18'(MEM_SIZE - 1), 18'h1F0F0);
        cycle();
        drive(0, 18'd5, 0);
        total++; if (memory_out !== 18'h2AAAA) begin bad++; $display("FAIL ram_addr5 got=%h want=%h", memory_out, 18'h2AAAA); end
        drive(0, 18'd5 + 18'(MEM_SIZE), 0);
        total++; if (memory_out !== 18'd0) begin bad++; $display("FAIL ram_unmapped got=%h want=%h", memory_out, 18'd0); end
        drive(0, 18'(MEM_SIZE - 1), 0);
        total++; if (memory_out !== 18'h1F0F0) begin bad++; $display("FAIL ram_top got=%h want=%h", memory_out, 18'h1F0F0); end
        cycle();
        for (int i = 0; i < 16; i++) begin
            drive(0, 18'(i), 0);
            total++; if (memory_out !== vals[i]) begin bad++; $display("FAIL ram_readback[%0d] got=%h want=%h", i, memory_out, vals[i]); end
            cycle();
        end
    endtask

    task automatic test_tx_overflow();
        tx_ready = 1'b0;
        rx_valid = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            drive(1, A_TX, 18'(i));
            cycle();
        end
        drive(0, A_STATUS, 0);
        total++; if (memory_out !== 18'h89) begin bad++; $display("FAIL ovf_status got=%h want=%h", memory_out, 18'h89); end
        cycle();
        tx_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            drive(0, A_TX, 0);
            total++; if (memory_out !== 18'd0) begin bad++; $display("FAIL txdata_read[%0d] got=%h want=0", i, memory_out); end
            total++; if (tx_valid !== 1'b1 || tx_data !== 18'(i)) begin
                bad++; $display("FAIL drain[%0d] got=%b/%h want=1/%h", i, tx_valid, tx_data, 18'(i));
            end
            cycle();
        end
        drive(0, A_STATUS, 0);
        total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL drain_empty got=%b want=0", tx_valid); end
        total++; if (memory_out !== 18'h0A) begin bad++; $display("FAIL ovf_sticky got=%h want=%h", memory_out, 18'h0A); end
        cycle();
        drive(1, A_STATUS, 18'h8);
        cycle();
        drive(0, A_STATUS, 0);
        total++; if (memory_out !== 18'h02) begin bad++; $display("FAIL ovf_clear got=%h want=%h", memory_out, 18'h02); end
        cycle();
        tx_ready = 1'b0;
    endtask

    task automatic test_full_push_pop();
        logic [17:0] exp;
        tx_ready = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            drive(1, A_TX, 18'h10 + 18'(i));
            cycle();
        end
        drive(0, A_STATUS, 0);
        total++; if (memory_out !== 18'h81) begin bad++; $display("FAIL full_status got=%h want=%h", memory_out, 18'h81); end
        cycle();
        tx_ready = 1'b1;
        drive(1, A_TX, 18'h123);
        cycle();
        tx_ready = 1'b0;
        drive(0, A_STATUS, 0);
        total++; if (memory_out !== 18'h81) begin bad++; $display("FAIL pushpop_status got=%h want=%h", memory_out, 18'h81); end
        cycle();
        tx_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            exp = (k < 7) ? 18'h12 + 18'(k) : 18'h123;
            #1;
            total++; if (tx_valid !== 1'b1 || tx_data !== exp) begin
                bad++; $display("FAIL pushpop_drain[%0d] got=%b/%h want=1/%h", k, tx_valid, tx_data, exp);
            end
            cycle();
        end
        #1;
        total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL pushpop_empty got=%b want=0", tx_valid); end
        tx_ready = 1'b0;
        cycle();
    endtask

    task automatic test_rx();
        rx_valid = 1'b1;
        rx_data  = 18'h00777;
        drive(0, A_RX, 0);
        total++; if (rx_ready !== 1'b1 || memory_out !== 18'd0) begin
            bad++; $display("FAIL rx_idle got=%b/%h want=1/0", rx_ready, memory_out);
        end
        cycle();
        rx_data = 18'h00555;
        drive(0, A_RX, 0);
        total++; if (rx_ready !== 1'b0 || memory_out !== 18'h00777) begin
            bad++; $display("FAIL rx_held got=%b/%h want=0/00777", rx_ready, memory_out);
        end
        cycle();
        drive(0, A_STATUS, 0);
        total++; if (memory_out !== 18'h06) begin bad++; $display("FAIL rx_status got=%h want=%h", memory_out, 18'h06); end
        cycle();
        drive(0, A_RX, 0);
        total++; if (memory_out !== 18'h00777) begin bad++; $display("FAIL rx_second_ignored got=%h want=%h", memory_out, 18'h00777); end
        drive(1, A_RX, 0);
        cycle();
        drive(0, A_RX, 0);
        total++; if (rx_ready !== 1'b1 || memory_out !== 18'd0) begin
            bad++; $display("FAIL rx_release got=%b/%h want=1/0", rx_ready, memory_out);
        end
        cycle();
        rx_valid = 1'b0;
        drive(0, A_RX, 0);
        total++; if (rx_ready !== 1'b0 || memory_out !== 18'h00555) begin
            bad++; $display("FAIL rx_second got=%b/%h want=0/00555", rx_ready, memory_out);
        end
        drive(1, A_RX, 0);
        cycle();
        drive(0, A_RX, 0);
        total++; if (rx_ready !== 1'b1) begin bad++; $display("FAIL rx_final_release got=%b want=1", rx_ready); end
        cycle();
    endtask

    task automatic test_cycles();
`ifdef MEMORY_IO_CYCLE_COUNTER_EN
        drive(1, A_CYC, 18'd100);
        cycle();
        drive(0, A_CYC, 0);
        total++; if (memory_out !== 18'd100) begin bad++; $display("FAIL cyc_load got=%h want=%h", memory_out, 18'd100); end
        cycle(); cycle(); cycle();
        total++; if (memory_out !== 18'd103) begin bad++; $display("FAIL cyc_count got=%h want=%h", memory_out, 18'd103); end
        drive(1, A_CYC, 18'h3FFFF);
        cycle();
        drive(0, A_CYC, 0);
        total++; if (memory_out !== 18'h3FFFF) begin bad++; $display("FAIL cyc_max got=%h want=%h", memory_out, 18'h3FFFF); end
        cycle();
        total++; if (memory_out !== 18'd0) begin bad++; $display("FAIL cyc_wrap got=%h want=0", memory_out); end
`else
        drive(1, A_CYC, 18'd100);
        cycle();
        drive(0, A_CYC, 0);
        total++; if (memory_out !== 18'd0) begin bad++; $display("FAIL cyc_off got=%h want=0", memory_out); end
        cycle(); cycle();
        total++; if (memory_out !== 18'd0) begin bad++; $display("FAIL cyc_off_later got=%h want=0", memory_out); end
`endif
        cycle();
    endtask

    task automatic test_reset_midflight();
        tx_ready = 1'b0;
        rx_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1, A_TX, 18'h31 + 18'(i));
            cycle();
        end
        rx_valid = 1'b1;
        rx_data  = 18'h000AB;
        drive(0, A_STATUS, 0);
        cycle();
        rx_valid = 1'b0;
        drive(0, A_STATUS, 0);
        total++; if (memory_out !== 18'h34 || tx_valid !== 1'b1 || rx_ready !== 1'b0) begin
            bad++; $display("FAIL pre_reset got=%h/%b/%b want=34/1/0", memory_out, tx_valid, rx_ready);
        end
        reset    = 1'b1;
        tx_ready = 1'b1;
        rx_valid = 1'b1;
        drive(1, A_TX, 18'h99);
        cycle();
        reset    = 1'b0;
        tx_ready = 1'b0;
        rx_valid = 1'b0;
        drive(0, A_STATUS, 0);
        total++; if (memory_out !== 18'h02 || tx_valid !== 1'b0 || rx_ready !== 1'b1) begin
            bad++; $display("FAIL post_reset got=%h/%b/%b want=02/0/1", memory_out, tx_valid, rx_ready);
        end
        cycle();
        drive(0, 18'd5, 0);
        total++; if (memory_out !== 18'h2AAAA) begin bad++; $display("FAIL ram_survives_reset got=%h want=%h", memory_out, 18'h2AAAA); end
        cycle();
    endtask

    task automatic test_random();
        logic [17:0] a;
        logic [17:0] exp;
        for (int n = 0; n < 600; n++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: a = 18'($urandom_range(0, 15));
                4, 5:       a = A_TX;
                6:          a = A_STATUS;
                7:          a = A_RX;
                8:          a = A_CYC;
                default:    a = ($urandom_range(0, 1) == 0) ? IO_BASE + 18'd4 : 18'd1024 + 18'($urandom_range(0, 200));
            endcase
            tx_ready = ($urandom_range(0, 9) < 3);
            rx_valid = ($urandom_range(0, 1) == 1);
            rx_data  = 18'($urandom);
            drive(($urandom_range(0, 1) == 1), a, 18'($urandom));
            exp = model_read(a);
            if (!$isunknown(exp)) begin
                total++; if (memory_out !== exp) begin bad++; $display("FAIL rnd_read[%0d] addr=%h got=%h want=%h", n, a, memory_out, exp); end
            end
            total++; if (tx_valid !== (m_fifo.size() != 0)) begin
                bad++; $display("FAIL rnd_tx_valid[%0d] got=%b want=%b", n, tx_valid, m_fifo.size() != 0);
            end
            if (m_fifo.size() != 0) begin
                total++; if (tx_data !== m_fifo[0]) begin bad++; $display("FAIL rnd_tx_data[%0d] got=%h want=%h", n, tx_data, m_fifo[0]); end
            end
            total++; if (rx_ready !== !m_held) begin bad++; $display("FAIL rnd_rx_ready[%0d] got=%b want=%b", n, rx_ready, !m_held); end
            cycle();
        end
        memory_write_enable = 1'b0;
        tx_ready = 1'b0;
        rx_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_ram();
        test_tx_overflow();
        test_full_push_pop();
        test_rx();
        test_cycles();
        test_reset_midflight();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
